hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl
//  Purpose  : Hazard unit for a 5-stage in-order pipeline. It classifies
//             each cycle as RUN, LOAD_STALL, FLUSH or FREEZE, drives the
//             matching stall/bubble/flush/freeze controls, selects the EX
//             operand forwarding sources, and counts hazard events in
//             saturating counters.
//  Ports    : clk, reset_n (async, active-low)
//             id_valid, id_rs1, id_rs2         - instruction in ID
//             ex_rs1, ex_rs2, ex_rd, ex_regwen,
//             ex_wbsel, ex_pcsel               - instruction in EX
//             dmem_ready                       - 0 freezes the pipeline
//             cnt_clr                          - sync clear of counters
//             stall_pc, stall_ifid, bubble_idex,
//             flush_ifid, freeze               - pipeline controls
//             fwd_a, fwd_b                     - EX operand source selects
//             last_evt                         - previous-cycle event
//             stall_cnt, flush_cnt, freeze_cnt - event counters
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwen,
    input  logic [1:0]       ex_wbsel,
    input  logic             ex_pcsel,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             flush_ifid,
    output logic             freeze,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       last_evt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    typedef enum logic [1:0] {
        EVT_RUN        = 2'b00,
        EVT_LOAD_STALL = 2'b01,
        EVT_FLUSH      = 2'b10,
        EVT_FREEZE     = 2'b11
    } evt_t;

    localparam logic [1:0]       c_WB_MEM   = 2'b00;
    localparam logic [1:0]       c_FWD_RF   = 2'b00;
    localparam logic [1:0]       c_FWD_MEM  = 2'b01;
    localparam logic [1:0]       c_FWD_WB   = 2'b10;
    localparam logic [4:0]       c_X0       = 5'd0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

    // Shadow copies of the destination info held in the MEM and WB stages.
    logic [4:0]       r_mem_rd;
    logic             r_mem_regwen;
    logic [4:0]       r_wb_rd;
    logic             r_wb_regwen;
    logic [1:0]       r_last_evt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_freeze_cnt;

    logic             w_load_use;
    evt_t             w_evt;

    // A load in EX whose result is needed by the instruction in ID cannot
    // be forwarded in time; x0 is never a real dependency.
    assign w_load_use = id_valid && ex_regwen && (ex_wbsel == c_WB_MEM) &&
                        (ex_rd != c_X0) &&
                        ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Event classification, highest priority first. A taken branch/jump
    // squashes the ID instruction, so its load-use hazard is moot.
    always_comb begin
        w_evt = EVT_RUN;
        if (!dmem_ready) begin
            w_evt = EVT_FREEZE;
        end else if (ex_pcsel) begin
            w_evt = EVT_FLUSH;
        end else if (w_load_use) begin
            w_evt = EVT_LOAD_STALL;
        end
    end

    // Control outputs; everything is forced low while reset is asserted.
    always_comb begin
        stall_pc    = 1'b0;
        stall_ifid  = 1'b0;
        bubble_idex = 1'b0;
        flush_ifid  = 1'b0;
        freeze      = 1'b0;
        if (reset_n) begin
            case (w_evt)
                EVT_FREEZE: begin
                    freeze = 1'b1;
                end
                EVT_FLUSH: begin
                    flush_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end
                EVT_LOAD_STALL: begin
                    stall_pc    = 1'b1;
                    stall_ifid  = 1'b1;
                    bubble_idex = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Forwarding selects. MEM holds the younger result so it wins over WB.
    // The tracking registers hold during a freeze, keeping these valid.
    always_comb begin
        fwd_a = c_FWD_RF;
        fwd_b = c_FWD_RF;
        if (reset_n) begin
            if (r_mem_regwen && (r_mem_rd != c_X0) && (r_mem_rd == ex_rs1)) begin
                fwd_a = c_FWD_MEM;
            end else if (r_wb_regwen && (r_wb_rd != c_X0) && (r_wb_rd == ex_rs1)) begin
                fwd_a = c_FWD_WB;
            end
            if (r_mem_regwen && (r_mem_rd != c_X0) && (r_mem_rd == ex_rs2)) begin
                fwd_b = c_FWD_MEM;
            end else if (r_wb_regwen && (r_wb_rd != c_X0) && (r_wb_rd == ex_rs2)) begin
                fwd_b = c_FWD_WB;
            end
        end
    end

    // MEM/WB tracking and last-event register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_rd     <= 5'd0;
            r_mem_regwen <= 1'b0;
            r_wb_rd      <= 5'd0;
            r_wb_regwen  <= 1'b0;
            r_last_evt   <= EVT_RUN;
        end else begin
            if (w_evt != EVT_FREEZE) begin
                r_mem_rd     <= ex_rd;
                r_mem_regwen <= ex_regwen;
                r_wb_rd      <= r_mem_rd;
                r_wb_regwen  <= r_mem_regwen;
            end
            r_last_evt <= w_evt;
        end
    end

    // Saturating event counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else if (cnt_clr) begin
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            if ((w_evt == EVT_LOAD_STALL) && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if ((w_evt == EVT_FLUSH) && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
            if ((w_evt == EVT_FREEZE) && (r_freeze_cnt != c_CNT_MAX)) begin
                r_freeze_cnt <= r_freeze_cnt + c_CNT_ONE;
            end
        end
    end

    assign last_evt   = r_last_evt;
    assign stall_cnt  = r_stall_cnt;
    assign flush_cnt  = r_flush_cnt;
    assign freeze_cnt = r_freeze_cnt;

endmodule
`default_nettype wire
